inner_prod_driver: RTL and testbench

//  Initiator for the vector inner-product stream: holds two VEC_LEN-element operand vectors,

---
 rtl/ip_pkg.sv | 16 +
 rtl/vec_regfile.sv | 42 ++++
 rtl/inner_prod_driver.sv | 110 +++++++++++
 tb/tb_inner_prod_driver.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared constants and FSM state encoding for the vector inner-product stream.
// Imported by the driver and by the inner-product unit it feeds.
package ip_pkg;

    localparam int VEC_LEN = 8;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 19;
    localparam int ADDR_W  = $clog2(VEC_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/vec_regfile.sv
// Dual VEC_LEN x DATA_W operand file: one write port selecting A or B,
// two asynchronous read ports sharing a common element index.
module vec_regfile
    import ip_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              sel,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] a_rd,
    output logic [DATA_W-1:0] b_rd
);

    logic [DATA_W-1:0] a_mem [VEC_LEN];
    logic [DATA_W-1:0] b_mem [VEC_LEN];
    logic              addr_ok;

    assign addr_ok = ({1'b0, waddr} < (ADDR_W + 1)'(VEC_LEN));

    // NOTE: the files must read as zero after reset, so they are flops with a reset, not a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (we && addr_ok) begin
            if (sel) begin
                b_mem[waddr] <= wdata;
            end else begin
                a_mem[waddr] <= wdata;
            end
        end
    end

    assign a_rd = a_mem[raddr];
    assign b_rd = b_mem[raddr];

endmodule

// File: rtl/inner_prod_driver.sv
// Initiator for the inner-product stream: sends VEC_LEN operand pairs back-to-back,
// waits for the unit's result strobe and checks it against its own running sum.
module inner_prod_driver
    import ip_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    input  logic [RES_W-1:0]  res_in,
    input  logic              res_valid,
    output logic [RES_W-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              mismatch,
    output logic              timeout_err
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_e              state;
    logic [ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]    wait_cnt;
    logic [RES_W-1:0]    ref_sum;
    logic [DATA_W-1:0]   a_rd;
    logic [DATA_W-1:0]   b_rd;
    logic [2*DATA_W-1:0] prod;

    vec_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (load_en && (state == IDLE)),
        .sel   (load_sel),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx),
        .a_rd  (a_rd),
        .b_rd  (b_rd)
    );

    assign prod = {{DATA_W{1'b0}}, a_rd} * {{DATA_W{1'b0}}, b_rd};

    // Stream outputs decode from state so a reset drops valid_out without waiting for a clock.
    assign valid_out = (state == SEND);
    assign busy      = (state != IDLE);
    assign a_out     = valid_out ? a_rd : '0;
    assign b_out     = valid_out ? b_rd : '0;

    // NOTE: non-blocking assignments so every register updates from its pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            ref_sum     <= '0;
            result      <= '0;
            done        <= 1'b0;
            mismatch    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SEND;
                        idx         <= '0;
                        ref_sum     <= '0;
                        mismatch    <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                SEND: begin
                    ref_sum <= ref_sum + RES_W'(prod);
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    // A strobe arriving on the expiry cycle wins over the timeout.
                    if (res_valid) begin
                        result   <= res_in;
                        mismatch <= mismatch | (res_in != ref_sum);
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else if (wait_cnt == LAST_CNT) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inner_prod_driver.sv
// Bench for inner_prod_driver: a behavioural inner-product unit (with stub modes for
// wrong, late or missing results) plus a vector-level reference model of the operand files.
module tb_inner_prod_driver;
    import ip_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_en = 1'b0;
    logic              load_sel = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              valid_out;
    logic [RES_W-1:0]  res_in;
    logic              res_valid;
    logic [RES_W-1:0]  result;
    logic              done;
    logic              busy;
    logic              mismatch;
    logic              timeout_err;

    logic              unit_valid = 1'b0;
    logic [RES_W-1:0]  unit_res = '0;
    logic              spur_valid = 1'b0;
    logic [RES_W-1:0]  spur_res = '0;

    assign res_valid = unit_valid | spur_valid;
    assign res_in    = spur_valid ? spur_res : unit_res;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;  // 0 nominal unit, 1 returns sum+1, 2 never answers
    int delay   = 0;  // extra cycles before the unit strobes its result

    int unsigned ma [VEC_LEN];
    int unsigned mb [VEC_LEN];

    int cyc = 0, nvalid = 0, ndone = 0, first_v = -1, last_v = -1, done_cyc = -1, busy_cnt = 0;
    int unsigned obs_a [$];
    int unsigned obs_b [$];

    inner_prod_driver #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_sel    (load_sel),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .a_out       (a_out),
        .b_out       (b_out),
        .valid_out   (valid_out),
        .res_in      (res_in),
        .res_valid   (res_valid),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .mismatch    (mismatch),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural inner-product unit: sums each burst, answers after the burst ends.
    int unsigned acc = 0;
    bit          prev_v = 1'b0;
    int          k = -1;
    always @(negedge clk) begin
        unit_valid = 1'b0;
        if (!rst) begin
            acc = 0;
            prev_v = 1'b0;
            k = -1;
        end else begin
            if (valid_out) begin
                if (!prev_v) acc = 0;
                acc += int'(a_out) * int'(b_out);
                k = -1;
            end else if (prev_v) begin
                k = 0;
            end else if (k >= 0) begin
                k++;
            end
            if (!valid_out && k >= 0 && k == delay && mode != 2) begin
                unit_valid = 1'b1;
                unit_res = RES_W'(acc + ((mode == 1) ? 1 : 0));
                k = -1;
            end
            prev_v = valid_out;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (valid_out) begin
            if (nvalid == 0) first_v = cyc;
            last_v = cyc;
            nvalid++;
            obs_a.push_back(int'(a_out));
            obs_b.push_back(int'(b_out));
        end
        if (busy) busy_cnt++;
        if (done) begin
            if (ndone == 0) done_cyc = cyc;
            ndone++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nvalid = 0; ndone = 0; first_v = -1; last_v = -1; done_cyc = -1; busy_cnt = 0;
        obs_a.delete();
        obs_b.delete();
    endtask

    function automatic int unsigned model_sum();
        int unsigned s = 0;
        for (int i = 0; i < VEC_LEN; i++) s += ma[i] * mb[i];
        return s;
    endfunction

    function automatic int stream_errs();
        int e = 0;
        if (obs_a.size() != VEC_LEN || obs_b.size() != VEC_LEN) return VEC_LEN + 1;
        for (int i = 0; i < VEC_LEN; i++) if (obs_a[i] != ma[i] || obs_b[i] != mb[i]) e++;
        return e;
    endfunction

    task automatic load(input bit sel, input int addr, input int unsigned data);
        load_en = 1'b1; load_sel = sel; load_addr = ADDR_W'(addr); load_data = DATA_W'(data);
        step();
        load_en = 1'b0;
        if (sel) mb[addr] = data % 256; else ma[addr] = data % 256;
    endtask

    // kind 0: 1..N, kind 1: all 255, otherwise random
    task automatic load_vectors(input int kind);
        for (int i = 0; i < VEC_LEN; i++) begin
            load(1'b0, i, (kind == 0) ? i + 1 : (kind == 1) ? 255 : $urandom_range(255));
            load(1'b1, i, (kind == 0) ? i + 1 : (kind == 1) ? 255 : $urandom_range(255));
        end
    endtask

    task automatic run(input int mode_i, input int delay_i, input bit disturb, output int c0);
        mode = mode_i; delay = delay_i;
        clear_mon();
        c0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0; load_en = 1'b0;
        for (int i = 0; i < 60 && ndone == 0; i++) begin
            if (disturb && i < 7) begin
                start = 1'b1; load_en = 1'b1;
                load_sel = 1'($urandom); load_addr = ADDR_W'($urandom); load_data = DATA_W'($urandom);
                spur_valid = (i == 3); spur_res = 19'h12345;
            end
            step();
            start = 1'b0; load_en = 1'b0; spur_valid = 1'b0;
        end
        n_tests++;
        if (ndone == 0) begin n_fail++; $display("FAIL run_done: done count %0d, want 1 within budget", ndone); end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if ({a_out, b_out} !== '0) begin n_fail++; $display("FAIL reset_ab: got %h/%h want 0/0", a_out, b_out); end
        n_tests++; if (result !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %0d done %b want 0 0", result, done); end
        n_tests++; if ({mismatch, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", mismatch, timeout_err); end
        rst = 1'b1;
        for (int i = 0; i < VEC_LEN; i++) begin ma[i] = 0; mb[i] = 0; end
        step();
    endtask

    task automatic test_basic();
        int c0;
        load_vectors(0);
        run(0, 0, 1'b0, c0);
        n_tests++; if (nvalid != VEC_LEN || last_v - first_v != VEC_LEN - 1) begin n_fail++; $display("FAIL basic_burst: %0d valid over span %0d, want %0d contiguous", nvalid, last_v - first_v + 1, VEC_LEN); end
        n_tests++; if (first_v != c0 + 1) begin n_fail++; $display("FAIL basic_latency: first valid at %0d want %0d", first_v, c0 + 1); end
        n_tests++; if (stream_errs() != 0) begin n_fail++; $display("FAIL basic_stream: %0d element errors want 0", stream_errs()); end
        n_tests++; if (result !== RES_W'(model_sum()) || model_sum() != 204) begin n_fail++; $display("FAIL basic_result: got %0d want 204", result); end
        n_tests++; if (ndone != 1 || done_cyc != c0 + 10) begin n_fail++; $display("FAIL basic_done: %0d pulses at %0d want 1 at %0d", ndone, done_cyc, c0 + 10); end
        n_tests++; if (busy_cnt != VEC_LEN + 1) begin n_fail++; $display("FAIL basic_busy: got %0d cycles want %0d", busy_cnt, VEC_LEN + 1); end
        n_tests++; if ({mismatch, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b%b want 00", mismatch, timeout_err); end
    endtask

    task automatic test_max_and_random();
        int c0;
        for (int t = 0; t < 5; t++) begin
            load_vectors(t == 0 ? 1 : 2);
            run(0, 0, 1'b0, c0);
            n_tests++; if (result !== RES_W'(model_sum()) || stream_errs() != 0) begin n_fail++; $display("FAIL data_run%0d: result %0d want %0d, %0d stream errors", t, result, model_sum(), stream_errs()); end
            n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL data_mismatch%0d: got %b want 0", t, mismatch); end
        end
    endtask

    task automatic test_mismatch();
        int c0;
        load_vectors(2);
        run(1, 0, 1'b0, c0);
        n_tests++; if (mismatch !== 1'b1 || result !== RES_W'(model_sum() + 1)) begin n_fail++; $display("FAIL mismatch_set: flag %b result %0d want 1 %0d", mismatch, result, model_sum() + 1); end
        repeat (5) step();
        n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %b want 1", mismatch); end
        run(0, 0, 1'b0, c0);
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mismatch_clear: got %b want 0", mismatch); end
    endtask

    task automatic test_timeout();
        int c0;
        logic [RES_W-1:0] prev_res;
        prev_res = result;
        load_vectors(2);
        run(2, 0, 1'b0, c0);
        n_tests++; if (timeout_err !== 1'b1 || result !== prev_res) begin n_fail++; $display("FAIL timeout_flag: err %b result %0d want 1 %0d", timeout_err, result, prev_res); end
        n_tests++; if (ndone != 1 || done_cyc != c0 + 25 || busy_cnt != VEC_LEN + 16) begin n_fail++; $display("FAIL timeout_timing: done at %0d busy %0d want %0d %0d", done_cyc, busy_cnt, c0 + 25, VEC_LEN + 16); end
        run(0, 15, 1'b0, c0);
        n_tests++; if (timeout_err !== 1'b0 || result !== RES_W'(model_sum()) || done_cyc != c0 + 25) begin n_fail++; $display("FAIL expiry_capture: err %b result %0d done %0d want 0 %0d %0d", timeout_err, result, done_cyc, model_sum(), c0 + 25); end
    endtask

    task automatic test_idle_res_valid();
        logic [RES_W-1:0] prev_res;
        prev_res = result;
        clear_mon();
        spur_valid = 1'b1; spur_res = prev_res + 19'd5;
        step();
        spur_valid = 1'b0;
        step();
        n_tests++; if (result !== prev_res || ndone != 0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL idle_res_valid: result %0d done %0d mm %b want %0d 0 0", result, ndone, mismatch, prev_res); end
    endtask

    task automatic test_busy_ignore();
        int c0;
        load_vectors(2);
        run(0, 0, 1'b1, c0);
        n_tests++; if (nvalid != VEC_LEN || ndone != 1 || stream_errs() != 0) begin n_fail++; $display("FAIL busy_burst: %0d valid %0d done %0d errors want %0d 1 0", nvalid, ndone, stream_errs(), VEC_LEN); end
        n_tests++; if (result !== RES_W'(model_sum()) || mismatch !== 1'b0) begin n_fail++; $display("FAIL busy_result: got %0d mm %b want %0d 0", result, mismatch, model_sum()); end
        run(0, 0, 1'b0, c0);
        n_tests++; if (stream_errs() != 0) begin n_fail++; $display("FAIL busy_readback: %0d element errors want 0", stream_errs()); end
    endtask

    task automatic test_load_with_start();
        int c0;
        int unsigned v;
        v = $urandom_range(255);
        load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = DATA_W'(v);
        ma[0] = v;
        run(0, 0, 1'b0, c0);
        n_tests++; if (stream_errs() != 0 || result !== RES_W'(model_sum())) begin n_fail++; $display("FAIL load_start: a0 %0d result %0d want %0d %0d", obs_a.size() > 0 ? obs_a[0] : 0, result, v, model_sum()); end
    endtask

    task automatic test_reset_mid_send();
        int c0;
        load_vectors(2);
        clear_mon();
        mode = 0; delay = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && nvalid < 4; i++) step();
        n_tests++; if (nvalid != 4) begin n_fail++; $display("FAIL rst_mid_reach: %0d valid seen want 4", nvalid); end
        rst = 1'b0;
        #1;
        n_tests++; if (valid_out !== 1'b0 || busy !== 1'b0 || {a_out, b_out} !== '0) begin n_fail++; $display("FAIL rst_mid_async: valid %b busy %b a %0d b %0d want 0 0 0 0", valid_out, busy, a_out, b_out); end
        n_tests++; if (result !== '0 || done !== 1'b0 || {mismatch, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_regs: result %0d done %b flags %b%b want 0 0 00", result, done, mismatch, timeout_err); end
        step();
        rst = 1'b1;
        for (int i = 0; i < VEC_LEN; i++) begin ma[i] = 0; mb[i] = 0; end
        step();
        run(0, 0, 1'b0, c0);
        n_tests++; if (stream_errs() != 0 || result !== '0) begin n_fail++; $display("FAIL rst_files_cleared: result %0d errors %0d want 0 0", result, stream_errs()); end
        load_vectors(2);
        run(0, 0, 1'b0, c0);
        n_tests++; if (nvalid != VEC_LEN || result !== RES_W'(model_sum()) || mismatch !== 1'b0) begin n_fail++; $display("FAIL rst_rerun: %0d valid result %0d want %0d %0d", nvalid, result, VEC_LEN, model_sum()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_and_random();
        test_mismatch();
        test_timeout();
        test_idle_res_valid();
        test_busy_ignore();
        test_load_with_start();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
